// File: rtl/alu_cmp_arbiter.sv
// Two-port round-robin front end for a shared 64-bit SUB/SLT/SLTU unit.
// One transaction in flight: IDLE grants, EXEC computes, RESP holds the result.
module alu_cmp_arbiter #(
  parameter int W   = 64,
  parameter int OPW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [OPW-1:0] req_op0,
  input  logic [OPW-1:0] req_op1,
  input  logic [W-1:0]   req_a0,
  input  logic [W-1:0]   req_a1,
  input  logic [W-1:0]   req_b0,
  input  logic [W-1:0]   req_b1,
  output logic [1:0]     rsp_valid,
  input  logic [1:0]     rsp_ready,
  output logic [W-1:0]   rsp_data,
  output logic           rsp_zero,
  output logic           rsp_err,
  output logic           busy
);

  localparam logic [OPW-1:0] OP_SUB  = OPW'(0);
  localparam logic [OPW-1:0] OP_SLT  = OPW'(1);
  localparam logic [OPW-1:0] OP_SLTU = OPW'(2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [OPW-1:0] op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
  } op_t;

  state_t state;
  state_t state_nx;
  op_t    req_q;
  logic   owner;
  logic   rr_ptr;
  logic   gnt_vld;
  logic   gnt_id;

  logic [W:0]   sub_w;
  logic [W-1:0] diff;
  logic         borrow;
  logic         ovf;
  logic [W-1:0] res;
  logic         err;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    unique case (1'b1)
      (req_valid == 2'b11): begin
        gnt_vld = 1'b1;
        gnt_id  = rr_ptr;
      end
      (req_valid == 2'b01): begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b0;
      end
      (req_valid == 2'b10): begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nx  = state;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    unique case (state)
      IDLE: begin
        if (gnt_vld) begin
          req_ready = gnt_id ? 2'b10 : 2'b01;
          state_nx  = EXEC;
        end
      end
      EXEC: state_nx = RESP;
      RESP: begin
        rsp_valid = owner ? 2'b10 : 2'b01;
        if (rsp_ready[owner]) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Borrow of the widened subtract is the unsigned less-than.
  assign sub_w  = {1'b0, req_q.a} - {1'b0, req_q.b};
  assign diff   = sub_w[W-1:0];
  assign borrow = sub_w[W];
  assign ovf    = (req_q.a[W-1] ^ req_q.b[W-1]) &
                  (diff[W-1] ^ req_q.a[W-1]);

  always_comb begin
    res = '0;
    err = 1'b0;
    unique case (req_q.op)
      OP_SUB:  res = diff;
      OP_SLT:  res = {{(W-1){1'b0}}, diff[W-1] ^ ovf};
      OP_SLTU: res = {{(W-1){1'b0}}, borrow};
      default: err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= 1'b0;
      owner    <= 1'b0;
      req_q    <= '0;
      rsp_data <= '0;
      rsp_zero <= 1'b0;
      rsp_err  <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && gnt_vld) begin
        owner  <= gnt_id;
        rr_ptr <= ~gnt_id;
        req_q  <= gnt_id ? {req_op1, req_a1, req_b1}
                         : {req_op0, req_a0, req_b0};
      end
      if (state == EXEC) begin
        rsp_data <= res;
        rsp_zero <= (res == '0);
        rsp_err  <= err;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_cmp_arbiter.sv
// Randomized self-checking bench for alu_cmp_arbiter.
// Reference: signed/unsigned compares and modular subtract in plain arithmetic.
module tb_alu_cmp_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_op0;
  logic [1:0]  req_op1;
  logic [63:0] req_a0;
  logic [63:0] req_a1;
  logic [63:0] req_b0;
  logic [63:0] req_b1;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [63:0] rsp_data;
  logic        rsp_zero;
  logic        rsp_err;
  logic        busy;

  int checks = 0;
  int errors = 0;
  bit exp_rr;
  logic [1:0]  cur_op [2];
  logic [63:0] cur_a  [2];
  logic [63:0] cur_b  [2];

  always #5 clk = ~clk;

  alu_cmp_arbiter #(.W(64), .OPW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_a1(req_a1),
    .req_b0(req_b0), .req_b1(req_b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero),
    .rsp_err(rsp_err), .busy(busy)
  );

  function automatic logic [63:0] model(input logic [1:0] op,
                                        input logic [63:0] a,
                                        input logic [63:0] b);
    case (op)
      2'd0: return a - b;
      2'd1: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      2'd2: return (a < b) ? 64'd1 : 64'd0;
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(6, 0))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h7FFF_FFFF_FFFF_FFFF;
      4: return 64'($urandom_range(3, 0));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic [1:0] op,
                         input logic [63:0] a, input logic [63:0] b);
    cur_op[p] = op;
    cur_a[p]  = a;
    cur_b[p]  = b;
    if (p == 0) begin
      req_op0 = op; req_a0 = a; req_b0 = b; req_valid[0] = 1'b1;
    end else begin
      req_op1 = op; req_a1 = a; req_b1 = b; req_valid[1] = 1'b1;
    end
  endtask

  task automatic rand_req(input int p, input bit allow_rsv);
    logic [1:0] op;
    op = allow_rsv ? 2'($urandom_range(3, 0)) : 2'($urandom_range(2, 0));
    set_req(p, op, pick(), pick());
  endtask

  task automatic get_grant(output int gp);
    gp = -1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (req_ready == 2'b01) gp = 0;
      else if (req_ready == 2'b10) gp = 1;
      @(posedge clk);
      #1;
      if (gp >= 0) begin
        exp_rr = (gp == 0);
        break;
      end
    end
  endtask

  task automatic wait_rsp(input int p, output bit ok);
    logic [1:0] m;
    m  = (p == 0) ? 2'b01 : 2'b10;
    ok = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid == m) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic ack(input int p);
    rsp_ready[p] = 1'b1;
    tick();
    rsp_ready = 2'b00;
  endtask

  task automatic single(input int p, input logic [1:0] op,
                        input logic [63:0] a, input logic [63:0] b,
                        output bit ok);
    int gp;
    bit r;
    set_req(p, op, a, b);
    get_grant(gp);
    req_valid[p] = 1'b0;
    wait_rsp(p, r);
    ok = r && (gp == p);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_op0 = '0; req_op1 = '0;
    req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
    tick(); tick();
    checks++;
    if ({req_ready, rsp_valid, rsp_zero, rsp_err, busy} !== 7'b0 ||
        rsp_data !== 64'd0) begin
      errors++;
      $display("FAIL reset_vals: rdy=%b vld=%b z=%b e=%b busy=%b data=%h want all 0",
               req_ready, rsp_valid, rsp_zero, rsp_err, busy, rsp_data);
    end
    rst_n = 1'b1;
    exp_rr = 1'b0;
    tick();
  endtask

  task automatic test_sub_latency();
    int gp;
    set_req(0, 2'd0, 64'd5, 64'd7);
    get_grant(gp);
    req_valid[0] = 1'b0;
    checks++;
    if (gp !== 0 || rsp_valid !== 2'b00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL sub_n1: gp=%0d vld=%b busy=%b want 0 00 1",
               gp, rsp_valid, busy);
    end
    tick();
    checks++;
    if (rsp_valid !== 2'b01 || rsp_data !== 64'hFFFF_FFFF_FFFF_FFFE ||
        rsp_zero !== 1'b0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL sub_n2: vld=%b data=%h z=%b e=%b want 01 fffffffffffffffe 0 0",
               rsp_valid, rsp_data, rsp_zero, rsp_err);
    end
    ack(0);
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 2'b00) begin
      errors++;
      $display("FAIL sub_done: busy=%b vld=%b want 0 00", busy, rsp_valid);
    end
  endtask

  task automatic test_slt_sltu();
    bit ok;
    single(0, 2'd2, 64'h8000_0000_0000_0000, 64'd1, ok);
    checks++;
    if (!ok || rsp_data !== 64'd0 || rsp_zero !== 1'b1) begin
      errors++;
      $display("FAIL sltu: ok=%b data=%h z=%b want 1 0 1", ok, rsp_data, rsp_zero);
    end
    ack(0);
    single(0, 2'd1, 64'h8000_0000_0000_0000, 64'd1, ok);
    checks++;
    if (!ok || rsp_data !== 64'd1 || rsp_zero !== 1'b0) begin
      errors++;
      $display("FAIL slt: ok=%b data=%h z=%b want 1 1 0", ok, rsp_data, rsp_zero);
    end
    ack(0);
  endtask

  task automatic test_reserved();
    bit ok;
    single(1, 2'd3, {$urandom, $urandom}, {$urandom, $urandom}, ok);
    checks++;
    if (!ok || rsp_valid !== 2'b10 || rsp_err !== 1'b1 ||
        rsp_data !== 64'd0 || rsp_zero !== 1'b1) begin
      errors++;
      $display("FAIL reserved: ok=%b vld=%b e=%b data=%h z=%b want 1 10 1 0 1",
               ok, rsp_valid, rsp_err, rsp_data, rsp_zero);
    end
    ack(1);
  endtask

  task automatic test_wrong_port();
    bit ok;
    single(0, 2'd0, 64'h1234, 64'h1234, ok);
    checks++;
    if (!ok || rsp_data !== 64'd0 || rsp_zero !== 1'b1) begin
      errors++;
      $display("FAIL equal_sub: ok=%b data=%h z=%b want 1 0 1", ok, rsp_data, rsp_zero);
    end
    rsp_ready = 2'b10;
    tick(); tick();
    checks++;
    if (rsp_valid !== 2'b01 || busy !== 1'b1 || rsp_zero !== 1'b1) begin
      errors++;
      $display("FAIL wrong_port: vld=%b busy=%b z=%b want 01 1 1",
               rsp_valid, busy, rsp_zero);
    end
    rsp_ready = 2'b00;
    ack(0);
  endtask

  task automatic test_reset_mid_resp();
    bit ok;
    int gp;
    single(0, 2'd0, pick(), pick(), ok);
    checks++;
    if (!ok || rsp_valid !== 2'b01) begin
      errors++;
      $display("FAIL pre_reset: ok=%b vld=%b want 1 01", ok, rsp_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 2'b00 || busy !== 1'b0 || rsp_data !== 64'd0) begin
      errors++;
      $display("FAIL async_reset: vld=%b busy=%b data=%h want 00 0 0",
               rsp_valid, busy, rsp_data);
    end
    tick();
    rst_n = 1'b1;
    exp_rr = 1'b0;
    rand_req(0, 1'b0);
    rand_req(1, 1'b0);
    get_grant(gp);
    req_valid = 2'b00;
    checks++;
    if (gp !== 0) begin
      errors++;
      $display("FAIL post_reset_grant: gp=%0d want 0", gp);
    end
    wait_rsp(0, ok);
    ack(0);
  endtask

  task automatic test_contention();
    int gp;
    bit want;
    bit ok;
    bit stalled = 1'b0;
    logic [1:0]  lop;
    logic [63:0] la;
    logic [63:0] lb;
    logic [63:0] exp;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_rr = 1'b0;
    rand_req(0, 1'b1);
    rand_req(1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      want = exp_rr;
      get_grant(gp);
      checks++;
      if (gp !== int'(want) || gp !== (k % 2)) begin
        errors++;
        $display("FAIL rr_grant[%0d]: gp=%0d want %0d", k, gp, want);
      end
      if (gp < 0) break;
      lop = cur_op[gp];
      la  = cur_a[gp];
      lb  = cur_b[gp];
      exp = model(lop, la, lb);
      rand_req(gp, 1'b1);
      wait_rsp(gp, ok);
      checks++;
      if (!ok || rsp_data !== exp || rsp_zero !== (exp == 64'd0) ||
          rsp_err !== (lop == 2'd3)) begin
        errors++;
        $display("FAIL rr_rsp[%0d]: ok=%b data=%h z=%b e=%b want %h op=%0d",
                 k, ok, rsp_data, rsp_zero, rsp_err, exp, lop);
      end
      if (gp == 1 && !stalled) begin
        stalled = 1'b1;
        for (int s = 0; s < 3; s++) begin
          tick();
          checks++;
          if (rsp_valid !== 2'b10 || rsp_data !== exp ||
              req_ready !== 2'b00 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stall[%0d]: vld=%b data=%h rdy=%b busy=%b want 10 %h 00 1",
                     s, rsp_valid, rsp_data, req_ready, busy, exp);
          end
        end
      end
      ack(gp);
    end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_random();
    int p;
    int gp;
    bit ok;
    logic [63:0] exp;
    for (int k = 0; k < 40; k++) begin
      p = $urandom_range(1, 0);
      rand_req(p, 1'b1);
      get_grant(gp);
      req_valid[p] = 1'b0;
      wait_rsp(p, ok);
      exp = model(cur_op[p], cur_a[p], cur_b[p]);
      checks++;
      if (!ok || gp !== p || rsp_data !== exp ||
          rsp_zero !== (exp == 64'd0) || rsp_err !== (cur_op[p] == 2'd3)) begin
        errors++;
        $display("FAIL rand[%0d]: p=%0d gp=%0d op=%0d a=%h b=%h data=%h z=%b e=%b want %h",
                 k, p, gp, cur_op[p], cur_a[p], cur_b[p],
                 rsp_data, rsp_zero, rsp_err, exp);
      end
      for (int d = $urandom_range(2, 0); d > 0; d--) tick();
      ack(p);
    end
  endtask

  initial begin
    test_reset();
    test_sub_latency();
    test_slt_sltu();
    test_reserved();
    test_wrong_port();
    test_reset_mid_resp();
    test_contention();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded 200000");
    $fatal(1);
  end

endmodule
